// File: rtl/armleocpu_ptw_ml_if.sv
// Armleobus data-port signals between the page table walker (master) and the bus (slave).
interface armleocpu_ptw_ml_if #(
    parameter int PA_WIDTH   = 34,
    parameter int DATA_WIDTH = 32
);
    logic                  m_transaction;
    logic [2:0]            m_cmd;
    logic [PA_WIDTH-1:0]   m_address;
    logic [2:0]            m_transaction_response;
    logic                  m_transaction_done;
    logic [DATA_WIDTH-1:0] m_rdata;

    modport master (
        output m_transaction,
        output m_cmd,
        output m_address,
        input  m_transaction_response,
        input  m_transaction_done,
        input  m_rdata
    );

    modport slave (
        input  m_transaction,
        input  m_cmd,
        input  m_address,
        output m_transaction_response,
        output m_transaction_done,
        output m_rdata
    );
endinterface

// File: rtl/armleocpu_ptw_ml.sv
// Multi-level page table walker: walks from satp_ppn to a leaf PTE over armleobus,
// with bare-mode bypass, abort with bus drain and superpage alignment checks.
module armleocpu_ptw_ml #(
    parameter int  LEVELS    = 2,
    parameter int  VPN_BITS  = 10,
    parameter int  PTE_BYTES = 4,
    parameter int  PPN_WIDTH = 22,
    localparam int LVL_W     = (LEVELS > 1) ? $clog2(LEVELS) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,

    armleocpu_ptw_ml_if.master           bus,

    input  logic                         resolve_request,
    output logic                         resolve_ack,
    input  logic                         resolve_abort,
    input  logic [LEVELS*VPN_BITS-1:0]   virtual_address,
    input  logic                         satp_mode,
    input  logic [PPN_WIDTH-1:0]         satp_ppn,

    output logic                         resolve_done,
    output logic                         resolve_pagefault,
    output logic                         resolve_accessfault,
    output logic [7:0]                   resolve_access_bits,
    output logic [PPN_WIDTH-1:0]         resolve_physical_address,
    output logic [LVL_W-1:0]             resolve_level
);

    localparam int PA_WIDTH = PPN_WIDTH + 12;
    localparam int PTE_W    = 8 * PTE_BYTES;
    localparam int OFS_W    = $clog2(PTE_BYTES);
    localparam int VA_W     = LEVELS * VPN_BITS;

    localparam logic [2:0] CMD_READ     = 3'd1;
    localparam logic [2:0] RESP_SUCCESS = 3'd0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WALK  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_ack;
    logic                   r_trans;
    logic [PA_WIDTH-1:0]    r_addr;
    logic [VA_W-1:0]        r_va;
    logic [LVL_W-1:0]       r_level;
    logic                   r_done;
    logic                   r_pf;
    logic                   r_af;
    logic [7:0]             r_bits;
    logic [PPN_WIDTH-1:0]   r_pa;
    logic [LVL_W-1:0]       r_level_out;

    logic [PTE_W-1:0]       w_pte;
    logic [PPN_WIDTH-1:0]   w_pte_ppn;
    logic [PPN_WIDTH-1:0]   w_mask;
    logic [PPN_WIDTH-1:0]   w_va_ext;
    logic                   w_is_leaf;
    logic                   w_invalid;
    logic                   w_misaligned;
    logic                   w_bad_ptr;
    logic [LVL_W-1:0]       w_level_dn;
    logic                   w_fin_af;
    logic                   w_fin_pf;
    logic                   w_descend;
    logic [7:0]             w_fin_bits;
    logic [PPN_WIDTH-1:0]   w_fin_ppn;
    logic                   w_unused;

    function automatic logic [VPN_BITS-1:0] vpn_at(input logic [VA_W-1:0] va,
                                                   input logic [LVL_W-1:0] lvl);
        logic [VPN_BITS-1:0] v;
        v = {VPN_BITS{1'b0}};
        for (int l = 0; l < LEVELS; l++) begin
            v = (int'(lvl) == l) ? va[l*VPN_BITS +: VPN_BITS] : v;
        end
        return v;
    endfunction

    // Ones in the PPN bits that a superpage at level lvl takes from the VA.
    function automatic logic [PPN_WIDTH-1:0] low_mask(input logic [LVL_W-1:0] lvl);
        logic [PPN_WIDTH-1:0] m;
        m = {PPN_WIDTH{1'b0}};
        for (int l = 0; l < LEVELS - 1; l++) begin
            m[l*VPN_BITS +: VPN_BITS] = (l < int'(lvl)) ? {VPN_BITS{1'b1}} : {VPN_BITS{1'b0}};
        end
        return m;
    endfunction

    function automatic logic [PA_WIDTH-1:0] pte_addr(input logic [PPN_WIDTH-1:0] ppn,
                                                     input logic [VA_W-1:0]      va,
                                                     input logic [LVL_W-1:0]     lvl);
        return {ppn, vpn_at(va, lvl), {OFS_W{1'b0}}};
    endfunction

    assign w_pte        = bus.m_rdata;
    assign w_pte_ppn    = w_pte[10 +: PPN_WIDTH];
    assign w_mask       = low_mask(r_level);
    assign w_va_ext     = PPN_WIDTH'(r_va);
    assign w_is_leaf    = w_pte[1] | w_pte[3];
    assign w_invalid    = ~w_pte[0] | (w_pte[2] & ~w_pte[1]);
    assign w_misaligned = |(w_pte_ppn & w_mask);
    assign w_bad_ptr    = w_pte[7] | w_pte[6] | w_pte[4] | (r_level == {LVL_W{1'b0}});
    assign w_level_dn   = r_level - LVL_W'(1);
    assign w_unused     = ^w_pte;

    // Classify the PTE of the current read in fault priority order.
    always_comb begin
        w_fin_af   = 1'b0;
        w_fin_pf   = 1'b0;
        w_descend  = 1'b0;
        w_fin_bits = 8'h00;
        w_fin_ppn  = {PPN_WIDTH{1'b0}};
        if (bus.m_transaction_response != RESP_SUCCESS) begin
            w_fin_af = 1'b1;
        end else if (w_invalid) begin
            w_fin_pf = 1'b1;
        end else if (w_is_leaf) begin
            if (w_misaligned) begin
                w_fin_pf = 1'b1;
            end else begin
                w_fin_bits = w_pte[7:0];
                w_fin_ppn  = (w_pte_ppn & ~w_mask) | (w_va_ext & w_mask);
            end
        end else if (w_bad_ptr) begin
            w_fin_pf = 1'b1;
        end else begin
            w_descend = 1'b1;
        end
    end

    // Walk state machine; every output is driven from a register here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ack       <= 1'b1;
            r_trans     <= 1'b0;
            r_addr      <= {PA_WIDTH{1'b0}};
            r_va        <= {VA_W{1'b0}};
            r_level     <= {LVL_W{1'b0}};
            r_done      <= 1'b0;
            r_pf        <= 1'b0;
            r_af        <= 1'b0;
            r_bits      <= 8'h00;
            r_pa        <= {PPN_WIDTH{1'b0}};
            r_level_out <= {LVL_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    r_pf   <= 1'b0;
                    r_af   <= 1'b0;
                    if (resolve_request) begin
                        r_va    <= virtual_address;
                        r_level <= LVL_W'(LEVELS - 1);
                        r_ack   <= 1'b0;
                        if (satp_mode) begin
                            r_state <= S_WALK;
                            r_trans <= 1'b1;
                            r_addr  <= pte_addr(satp_ppn, virtual_address, LVL_W'(LEVELS - 1));
                        end else begin
                            r_state     <= S_DONE;
                            r_done      <= 1'b1;
                            r_pa        <= PPN_WIDTH'(virtual_address);
                            r_bits      <= 8'hCF;
                            r_level_out <= {LVL_W{1'b0}};
                        end
                    end
                end
                S_WALK: begin
                    if (resolve_abort) begin
                        // An outstanding read must still complete before the bus is free.
                        if (bus.m_transaction_done) begin
                            r_state <= S_IDLE;
                            r_trans <= 1'b0;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (bus.m_transaction_done) begin
                        if (w_descend) begin
                            r_level <= w_level_dn;
                            r_addr  <= pte_addr(w_pte_ppn, r_va, w_level_dn);
                        end else begin
                            r_state     <= S_DONE;
                            r_trans     <= 1'b0;
                            r_done      <= 1'b1;
                            r_pf        <= w_fin_pf;
                            r_af        <= w_fin_af;
                            r_bits      <= w_fin_bits;
                            r_pa        <= w_fin_ppn;
                            r_level_out <= r_level;
                        end
                    end else begin
                        r_state <= S_WALK;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_pf    <= 1'b0;
                    r_af    <= 1'b0;
                    r_ack   <= 1'b1;
                end
                S_DRAIN: begin
                    if (bus.m_transaction_done) begin
                        r_state <= S_IDLE;
                        r_trans <= 1'b0;
                        r_ack   <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_trans <= 1'b0;
                    r_done  <= 1'b0;
                    r_pf    <= 1'b0;
                    r_af    <= 1'b0;
                    r_ack   <= 1'b1;
                end
            endcase
        end
    end

    assign bus.m_transaction         = r_trans;
    assign bus.m_cmd                 = CMD_READ;
    assign bus.m_address             = r_addr;
    assign resolve_ack               = r_ack;
    assign resolve_done              = r_done;
    assign resolve_pagefault         = r_pf;
    assign resolve_accessfault       = r_af;
    assign resolve_access_bits       = r_bits;
    assign resolve_physical_address  = r_pa;
    assign resolve_level             = r_level_out;

endmodule

// File: tb/tb_armleocpu_ptw_ml.sv
// Bench for armleocpu_ptw_ml: Sv32 and Sv39 instances checked against a walk model
// over a sparse PTE memory, plus directed abort, reset and bare-mode steps.
module tb_armleocpu_ptw_ml;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        req = 1'b0;
    logic        abort = 1'b0;
    logic        mode_i = 1'b0;
    logic        done_i = 1'b0;
    logic [2:0]  resp_i = 3'd0;
    logic [63:0] rdata_i = 64'd0;
    logic [63:0] satp_i = 64'd0;
    logic [63:0] va_i = 64'd0;

    int n_assert = 0;
    int n_fail = 0;
    bit rand_fill = 1'b0;
    logic [63:0] mem [longint];
    int          rsp [longint];

    armleocpu_ptw_ml_if #(.PA_WIDTH(34), .DATA_WIDTH(32)) bus32 ();
    armleocpu_ptw_ml_if #(.PA_WIDTH(56), .DATA_WIDTH(64)) bus39 ();

    assign bus32.m_transaction_done     = done_i & ~sel;
    assign bus32.m_transaction_response = resp_i;
    assign bus32.m_rdata                = rdata_i[31:0];
    assign bus39.m_transaction_done     = done_i & sel;
    assign bus39.m_transaction_response = resp_i;
    assign bus39.m_rdata                = rdata_i;

    logic ack32, done32, pf32, af32, ack39, done39, pf39, af39;
    logic [7:0]  bits32, bits39;
    logic [21:0] pa32;
    logic [43:0] pa39;
    logic [0:0]  lvl32;
    logic [1:0]  lvl39;

    armleocpu_ptw_ml dut32 (
        .clk(clk), .rst_n(rst_n), .bus(bus32),
        .resolve_request(req & ~sel), .resolve_ack(ack32), .resolve_abort(abort & ~sel),
        .virtual_address(va_i[19:0]), .satp_mode(mode_i), .satp_ppn(satp_i[21:0]),
        .resolve_done(done32), .resolve_pagefault(pf32), .resolve_accessfault(af32),
        .resolve_access_bits(bits32), .resolve_physical_address(pa32), .resolve_level(lvl32)
    );

    armleocpu_ptw_ml #(.LEVELS(3), .VPN_BITS(9), .PTE_BYTES(8), .PPN_WIDTH(44)) dut39 (
        .clk(clk), .rst_n(rst_n), .bus(bus39),
        .resolve_request(req & sel), .resolve_ack(ack39), .resolve_abort(abort & sel),
        .virtual_address(va_i[26:0]), .satp_mode(mode_i), .satp_ppn(satp_i[43:0]),
        .resolve_done(done39), .resolve_pagefault(pf39), .resolve_accessfault(af39),
        .resolve_access_bits(bits39), .resolve_physical_address(pa39), .resolve_level(lvl39)
    );

    logic        o_trans, o_ack, o_done, o_pf, o_af;
    logic [2:0]  o_cmd;
    logic [63:0] o_addr, o_pa;
    logic [7:0]  o_bits;
    logic [1:0]  o_lvl;

    always_comb begin
        if (sel) begin
            o_trans = bus39.m_transaction; o_cmd = bus39.m_cmd; o_addr = 64'(bus39.m_address);
            o_ack = ack39; o_done = done39; o_pf = pf39; o_af = af39;
            o_bits = bits39; o_pa = 64'(pa39); o_lvl = lvl39;
        end else begin
            o_trans = bus32.m_transaction; o_cmd = bus32.m_cmd; o_addr = 64'(bus32.m_address);
            o_ack = ack32; o_done = done32; o_pf = pf32; o_af = af32;
            o_bits = bits32; o_pa = 64'(pa32); o_lvl = {1'b0, lvl32};
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Random PTE for a table read at level lvl: pointers, aligned/misaligned leaves, bad encodings.
    function automatic longint gen_pte(input int lvl, input int vbits, input int ppnw);
        longint one, pp, low, fl;
        int k;
        one = 1;
        pp  = longint'({$urandom, $urandom}) & ((one << ppnw) - 1);
        low = (one << (lvl * vbits)) - 1;
        fl  = longint'(($urandom_range(0, 255) & 32'hFC) | 32'h03);
        k   = int'($urandom_range(0, 9));
        case (k)
            0, 1, 2, 3: return (pp << 10) | 1;
            4, 5:       return ((pp & ~low) << 10) | fl;
            6:          return (((pp & ~low) | ((lvl > 0) ? 1 : 0)) << 10) | fl;
            7:          return (pp << 10) | longint'($urandom_range(0, 255) & 32'hFE);
            8:          return (pp << 10) | 5;
            default:    return (pp << 10) | 64'h41;
        endcase
    endfunction

    // Reference translation straight from the walk rules, on the same sparse memory.
    task automatic model(input int levels, input int vbits, input int pteb, input int ppnw,
                         input bit mode, input longint satp, input longint va,
                         output bit pf, output bit af, output longint ppn, output int bits,
                         output int lvl_o, output longint q[$]);
        longint one, tbl, vpn, a, pte, pp, low;
        one = 1; tbl = satp; pf = 0; af = 0; ppn = 0; bits = 0; lvl_o = 0; q = {};
        if (!mode) begin
            ppn = va; bits = 'hCF;
            return;
        end
        for (int lvl = levels - 1; lvl >= 0; lvl--) begin
            vpn = (va >> (lvl * vbits)) & ((one << vbits) - 1);
            a = tbl * 4096 + vpn * pteb;
            q.push_back(a);
            if (rsp.exists(a) && rsp[a] != 0) begin af = 1; return; end
            pte = mem.exists(a) ? longint'(mem[a]) : 0;
            if (!pte[0] || (pte[2] && !pte[1])) begin pf = 1; return; end
            pp  = (pte >> 10) & ((one << ppnw) - 1);
            low = (one << (lvl * vbits)) - 1;
            if (pte[1] || pte[3]) begin
                if ((pp & low) != 0) begin pf = 1; return; end
                ppn = (pp & ~low) | (va & low); bits = int'(pte & 'hFF); lvl_o = lvl;
                return;
            end
            if (pte[7] || pte[6] || pte[4] || lvl == 0) begin pf = 1; return; end
            tbl = pp;
        end
    endtask

    // One request on instance s, acting as the bus with random latency, then compared to the model.
    task automatic run_walk(input bit s, input bit mode, input longint satp, input longint va);
        int levels, vbits, pteb, ppnw, cyc, last_done, bus_seen, wait_left, lvl, n, e_bits, e_lvl;
        bit got, pending, e_pf, e_af;
        longint cur_addr, e_ppn;
        longint addrs[$];
        longint q[$];
        levels = s ? 3 : 2; vbits = s ? 9 : 10; pteb = s ? 8 : 4; ppnw = s ? 44 : 22;
        got = 0; pending = 0; last_done = -1; bus_seen = 0; wait_left = 0; cur_addr = 0;
        @(negedge clk);
        sel = s; #1;
        check("ack_idle", 64'(o_ack), 64'd1);
        req = 1'b1; mode_i = mode; satp_i = satp; va_i = va;
        @(negedge clk);
        req = 1'b0; cyc = 1;
        while (!got && cyc < 100) begin
            done_i = 1'b0;
            if (o_done) begin
                got = 1'b1;
            end else begin
                if (o_trans) begin
                    bus_seen++;
                    check("cmd_read", 64'(o_cmd), 64'd1);
                    if (!pending) begin
                        pending = 1; cur_addr = o_addr; wait_left = int'($urandom_range(0, 3));
                    end else begin
                        check("addr_stable", o_addr, cur_addr);
                    end
                    if (wait_left == 0) begin
                        lvl = levels - 1 - addrs.size();
                        if (lvl < 0) lvl = 0;
                        if (rand_fill && !mem.exists(cur_addr)) mem[cur_addr] = gen_pte(lvl, vbits, ppnw);
                        if (rand_fill && !rsp.exists(cur_addr))
                            rsp[cur_addr] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 7)) : 0;
                        rdata_i = mem.exists(cur_addr) ? mem[cur_addr] : 64'd0;
                        resp_i  = rsp.exists(cur_addr) ? 3'(rsp[cur_addr]) : 3'd0;
                        addrs.push_back(cur_addr);
                        done_i = 1'b1; pending = 0; last_done = cyc;
                    end else begin
                        wait_left--;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        done_i = 1'b0;
        check("walk_timeout", 64'(got), 64'd1);
        if (got) begin
            model(levels, vbits, pteb, ppnw, mode, satp, va, e_pf, e_af, e_ppn, e_bits, e_lvl, q);
            check("trans_low_at_done", 64'(o_trans), 64'd0);
            check("latency", 64'(cyc), mode ? 64'(last_done + 1) : 64'd1);
            if (!mode) check("bare_no_bus", 64'(bus_seen), 64'd0);
            check("read_count", 64'(addrs.size()), 64'(q.size()));
            n = (addrs.size() < q.size()) ? addrs.size() : q.size();
            for (int i = 0; i < n; i++) check("read_addr", addrs[i], q[i]);
            check("pagefault", 64'(o_pf), 64'(e_pf));
            check("accessfault", 64'(o_af), 64'(e_af));
            if (!e_pf && !e_af) begin
                check("ppn", o_pa, e_ppn);
                check("access_bits", 64'(o_bits), 64'(e_bits));
                check("level", 64'(o_lvl), 64'(e_lvl));
            end
            @(negedge clk);
            check("done_one_cycle", 64'(o_done), 64'd0);
            check("pf_low_after", 64'(o_pf), 64'd0);
            check("af_low_after", 64'(o_af), 64'd0);
            check("ack_back", 64'(o_ack), 64'd1);
            if (!e_pf && !e_af) check("ppn_held", o_pa, e_ppn);
        end
    endtask

    initial begin
        logic [63:0] a0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sel = 1'b0; #1;
        check("rst_trans", 64'(o_trans), 64'd0);
        check("rst_ack", 64'(o_ack), 64'd1);
        check("rst_done", 64'(o_done), 64'd0);
        check("rst_flags", 64'({o_pf, o_af}), 64'd0);
        check("rst_bits", 64'(o_bits), 64'd0);
        check("rst_pa", o_pa, 64'd0);
        check("rst_level", 64'(o_lvl), 64'd0);
        sel = 1'b1; #1;
        check("rst39_trans", 64'(o_trans), 64'd0);
        check("rst39_ack", 64'(o_ack), 64'd1);

        rand_fill = 1'b0;
        mem.delete(); rsp.delete();
        mem[64'h1004] = 64'h801; mem[64'h2004] = 64'h123450CF;
        run_walk(1'b0, 1'b1, 64'h1, 64'h401);
        mem.delete(); mem[64'h1000] = 64'h2000000F;
        run_walk(1'b0, 1'b1, 64'h1, 64'h155);
        check("megapage_ppn", o_pa, 64'h80155);
        check("megapage_level", 64'(o_lvl), 64'd1);
        mem[64'h1000] = 64'h2000040F;
        run_walk(1'b0, 1'b1, 64'h1, 64'h155);
        mem.delete(); rsp[64'h1004] = 1;
        run_walk(1'b0, 1'b1, 64'h1, 64'h401);
        rsp.delete(); mem[64'h1004] = 64'h801; mem[64'h2004] = 64'h1;
        run_walk(1'b0, 1'b1, 64'h1, 64'h401);
        mem.delete(); mem[64'h1004] = 64'h4;
        run_walk(1'b0, 1'b1, 64'h1, 64'h401);
        run_walk(1'b0, 1'b0, 64'h1, 64'hABCDE);
        check("bare_ppn", o_pa, 64'hABCDE);
        check("bare_bits", 64'(o_bits), 64'hCF);

        // Abort one cycle into WALK; the bus completes five cycles later.
        mem.delete(); rsp.delete();
        @(negedge clk);
        sel = 1'b0; req = 1'b1; mode_i = 1'b1; satp_i = 64'h1; va_i = 64'h401;
        @(negedge clk);
        req = 1'b0;
        check("abort_trans_rise", 64'(o_trans), 64'd1);
        a0 = o_addr; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("drain_trans_held", 64'(o_trans), 64'd1);
            check("drain_addr_held", o_addr, a0);
            check("drain_no_done", 64'(o_done), 64'd0);
            check("drain_no_ack", 64'(o_ack), 64'd0);
            @(negedge clk);
        end
        check("drain_trans_at_done", 64'(o_trans), 64'd1);
        rdata_i = 64'h801; resp_i = 3'd0; done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        check("drain_ack_back", 64'(o_ack), 64'd1);
        check("drain_trans_low", 64'(o_trans), 64'd0);
        check("drain_no_done_after", 64'(o_done), 64'd0);

        // Abort in the same cycle as bus completion.
        req = 1'b1;
        @(negedge clk);
        req = 1'b0; abort = 1'b1; done_i = 1'b1;
        @(negedge clk);
        abort = 1'b0; done_i = 1'b0;
        check("abort_done_ack", 64'(o_ack), 64'd1);
        check("abort_done_trans", 64'(o_trans), 64'd0);
        check("abort_done_no_done", 64'(o_done), 64'd0);
        @(negedge clk);
        check("abort_done_quiet", 64'(o_done), 64'd0);

        // Reset in the middle of a walk.
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("rstmid_trans_rise", 64'(o_trans), 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_trans", 64'(o_trans), 64'd0);
        check("rstmid_ack", 64'(o_ack), 64'd1);

        // Sv39: level-1 leaf (2 MiB) and a full three-level walk.
        mem.delete(); rsp.delete();
        mem[64'h10008] = (64'h20 << 10) | 64'h1;
        mem[64'h20010] = (64'hABC00 << 10) | 64'hCF;
        run_walk(1'b1, 1'b1, 64'h10, (64'd1 << 18) | (64'd2 << 9) | 64'd3);
        check("sv39_2m_ppn", o_pa, 64'hABC03);
        check("sv39_2m_level", 64'(o_lvl), 64'd1);
        mem[64'h20010] = (64'h30 << 10) | 64'h1;
        mem[64'h30018] = (64'h12345 << 10) | 64'h0B;
        run_walk(1'b1, 1'b1, 64'h10, (64'd1 << 18) | (64'd2 << 9) | 64'd3);

        rand_fill = 1'b1;
        for (int t = 0; t < 40; t++) begin
            mem.delete(); rsp.delete();
            run_walk(1'b0, 1'($urandom_range(0, 7) != 0), longint'($urandom_range(0, 32'h3FFFFF)),
                     longint'($urandom & 32'hFFFFF));
        end
        for (int t = 0; t < 25; t++) begin
            mem.delete(); rsp.delete();
            run_walk(1'b1, 1'($urandom_range(0, 7) != 0),
                     longint'({$urandom, $urandom}) & 64'hFFF_FFFF_FFFF,
                     longint'($urandom & 32'h7FFFFFF));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
